// File: rtl/constants_pkg.sv
// Shared datapath constants for the Argon core: machine word and ALU interface widths.
package constants_pkg;

  localparam int WORD_WIDTH   = 16;
  localparam int ALU_OP_WIDTH = 4;
  localparam int FLAG_WIDTH   = 8;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile_pkg.sv
// Argon register-file command encoding and the ALU-op sequencer state set.
package regfile_pkg;

  localparam int INDEX_WIDTH = 3;
  localparam int COM_WIDTH   = 3;

  // COM_NOP has no arm in the register file, so it falls through to the default (idle) decode.
  typedef enum logic [COM_WIDTH-1:0] {
    COM_READA    = 3'd0,
    COM_READB    = 3'd1,
    COM_LATCHC   = 3'd2,
    COM_LATCHF   = 3'd3,
    COM_LATCHSEL = 3'd4,
    COM_NOP      = 3'd7
  } rf_command_t;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SEL   = 4'd1,
    RDA   = 4'd2,
    RDB   = 4'd3,
    EXEC  = 4'd4,
    WB    = 4'd5,
    FLG   = 4'd6,
    FIN   = 4'd7,
    ABORT = 4'd8
  } seq_state_t;

endpackage

// File: rtl/regfile_sequencer.sv
// Single-issue sequencer: select, read A/B, run the ALU, write back C and optionally F.
// Outputs are registered copies of a decode of the next state and next captured values.
module regfile_sequencer
  import constants_pkg::*;
  import regfile_pkg::*;
#(
  parameter int ALU_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [INDEX_WIDTH-1:0]  i_srcA,
  input  logic [INDEX_WIDTH-1:0]  i_srcB,
  input  logic [INDEX_WIDTH-1:0]  i_dst,
  input  logic [ALU_OP_WIDTH-1:0] i_alu_op,
  input  logic                    i_set_flags,
  output logic                    o_rf_valid,
  output logic [COM_WIDTH-1:0]    o_rf_command,
  output logic [15:0]             o_rf_data,
  input  logic                    i_rf_valid,
  input  logic [15:0]             i_rf_data,
  output logic                    o_alu_start,
  output logic [15:0]             o_alu_a,
  output logic [15:0]             o_alu_b,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  input  logic                    i_alu_done,
  input  logic [15:0]             i_alu_result,
  input  logic [7:0]              i_alu_flags,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ALU_TIMEOUT - 1);

  seq_state_t               state, state_nx;
  logic [CNT_WIDTH-1:0]     cnt, cnt_nx;
  logic [INDEX_WIDTH-1:0]   src_a, src_a_nx, src_b, src_b_nx, dst, dst_nx;
  logic [ALU_OP_WIDTH-1:0]  op, op_nx;
  logic                     set_flags, set_flags_nx;
  word_t                    opnd_a, opnd_a_nx, opnd_b, opnd_b_nx, result, result_nx;
  logic [FLAG_WIDTH-1:0]    flags, flags_nx;

  logic                     rf_valid_nx, alu_start_nx, busy_nx, done_nx, err_nx, req_ready_nx;
  logic [COM_WIDTH-1:0]     rf_command_nx;
  word_t                    rf_data_nx, alu_a_nx, alu_b_nx;
  logic [ALU_OP_WIDTH-1:0]  alu_op_nx;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    src_a_nx     = src_a;
    src_b_nx     = src_b;
    dst_nx       = dst;
    op_nx        = op;
    set_flags_nx = set_flags;
    opnd_a_nx    = opnd_a;
    opnd_b_nx    = opnd_b;
    result_nx    = result;
    flags_nx     = flags;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          src_a_nx     = i_srcA;
          src_b_nx     = i_srcB;
          dst_nx       = i_dst;
          op_nx        = i_alu_op;
          set_flags_nx = i_set_flags;
          state_nx     = SEL;
        end
      end
      SEL: state_nx = RDA;
      RDA: begin
        opnd_a_nx = i_rf_data;
        state_nx  = i_rf_valid ? RDB : ABORT;
      end
      RDB: begin
        opnd_b_nx = i_rf_data;
        cnt_nx    = '0;
        state_nx  = i_rf_valid ? EXEC : ABORT;
      end
      EXEC: begin
        // cnt==0 marks the start-pulse cycle, where a done is not yet meaningful.
        if (cnt != '0 && i_alu_done) begin
          result_nx = i_alu_result;
          flags_nx  = i_alu_flags;
          if (dst != '0)      state_nx = WB;
          else if (set_flags) state_nx = FLG;
          else                state_nx = FIN;
        end else if (cnt == CNT_LAST) begin
          state_nx = ABORT;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WB:      state_nx = set_flags ? FLG : FIN;
      FLG:     state_nx = FIN;
      FIN:     state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rf_valid_nx   = 1'b0;
    rf_command_nx = COM_NOP;
    rf_data_nx    = '0;
    alu_start_nx  = 1'b0;
    alu_a_nx      = '0;
    alu_b_nx      = '0;
    alu_op_nx     = '0;
    done_nx       = 1'b0;
    err_nx        = 1'b0;
    busy_nx       = (state_nx != IDLE);
    req_ready_nx  = (state_nx == IDLE);
    case (state_nx)
      SEL: begin
        rf_valid_nx   = 1'b1;
        rf_command_nx = COM_LATCHSEL;
        rf_data_nx[3*INDEX_WIDTH-1:0] = {dst_nx, src_b_nx, src_a_nx};
      end
      RDA: rf_command_nx = COM_READA;
      RDB: rf_command_nx = COM_READB;
      EXEC: begin
        alu_start_nx = (state != EXEC);
        alu_a_nx     = opnd_a_nx;
        alu_b_nx     = opnd_b_nx;
        alu_op_nx    = op_nx;
      end
      WB: begin
        rf_valid_nx   = 1'b1;
        rf_command_nx = COM_LATCHC;
        rf_data_nx    = result_nx;
      end
      FLG: begin
        rf_valid_nx   = 1'b1;
        rf_command_nx = COM_LATCHF;
        rf_data_nx    = {8'h00, flags_nx};
      end
      FIN: done_nx = 1'b1;
      ABORT: begin
        done_nx = 1'b1;
        err_nx  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      src_a        <= '0;
      src_b        <= '0;
      dst          <= '0;
      op           <= '0;
      set_flags    <= 1'b0;
      opnd_a       <= '0;
      opnd_b       <= '0;
      result       <= '0;
      flags        <= '0;
      o_req_ready  <= 1'b1;
      o_rf_valid   <= 1'b0;
      o_rf_command <= COM_NOP;
      o_rf_data    <= '0;
      o_alu_start  <= 1'b0;
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_alu_op     <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      src_a        <= src_a_nx;
      src_b        <= src_b_nx;
      dst          <= dst_nx;
      op           <= op_nx;
      set_flags    <= set_flags_nx;
      opnd_a       <= opnd_a_nx;
      opnd_b       <= opnd_b_nx;
      result       <= result_nx;
      flags        <= flags_nx;
      o_req_ready  <= req_ready_nx;
      o_rf_valid   <= rf_valid_nx;
      o_rf_command <= rf_command_nx;
      o_rf_data    <= rf_data_nx;
      o_alu_start  <= alu_start_nx;
      o_alu_a      <= alu_a_nx;
      o_alu_b      <= alu_b_nx;
      o_alu_op     <= alu_op_nx;
      o_busy       <= busy_nx;
      o_done       <= done_nx;
      o_err        <= err_nx;
    end
  end

endmodule
